// File: rtl/st7735_pattern_gen.sv
// st7735_pattern_gen
//   RGB565 test-pattern source for the 128x160 ST7735 panel. Streams a
//   row-major raster (x fastest) through a valid/ready handshake, with
//   frame/line markers, into st7735_controller.
//
//   Ports:
//     clk        system clock (100 MHz)
//     rst        synchronous, active-high reset
//     pattern    pattern select, latched only when a frame starts
//     restart    one-cycle pulse: abandon the frame, restart at (0,0)
//     pix_valid  pixel/flags valid (held high once streaming)
//     pix_ready  consumer accepts the current pixel
//     pix_data   RGB565 {R5,G6,B5}
//     pix_sof    current pixel is (0,0)
//     pix_eol    current pixel is the last of its line
//     pix_eof    current pixel is the last of the frame
//     frame_cnt  completed-frame counter, wraps 255 -> 0
//
//   Build option: define PATTERN_ANIMATE_EN to scroll patterns 5-9
//   horizontally by one pixel per frame (x' = x + frame_cnt mod H_PIXELS).

module st7735_pattern_gen #(
    parameter int H_PIXELS    = 128,
    parameter int V_PIXELS    = 160,
    parameter int BAR_W       = 16,
    parameter int CHECK_SHIFT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  pattern,
    input  logic        restart,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [15:0] pix_data,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic [7:0]  frame_cnt
);

    localparam int XW        = $clog2(H_PIXELS);
    localparam int YW        = $clog2(V_PIXELS);
    localparam int BAR_SHIFT = $clog2(BAR_W);

    localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_PIXELS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t state, state_nxt;

    logic [XW-1:0] x, x_nxt;
    logic [YW-1:0] y, y_nxt;
    logic [3:0]    pat, pat_nxt;
    logic [7:0]    frame_cnt_nxt;
    logic          valid_nxt;
    logic [15:0]   data_nxt;
    logic          sof_nxt, eol_nxt, eof_nxt;
    logic [15:0]   xe, ye, xs;

    // Coordinates arrive zero-extended to 16 bits so any bit select past
    // the real x/y width reads as 0.
    function automatic logic [15:0] pixel_colour(input logic [3:0]  p,
                                                 input logic [15:0] px,
                                                 input logic [15:0] py);
        logic [15:0] bar;
        logic [15:0] xy;
        logic [15:0] colour;
        bar = px >> BAR_SHIFT;
        if (bar > 16'd7)
            bar = 16'd7;
        xy = px ^ py;
        case (p)
            4'd0:    colour = 16'h0000;
            4'd1:    colour = 16'hFFFF;
            4'd2:    colour = 16'hF800;
            4'd3:    colour = 16'h07E0;
            4'd4:    colour = 16'h001F;
            4'd5: begin
                case (bar[2:0])
                    3'd0:    colour = 16'hFFFF;
                    3'd1:    colour = 16'hFFE0;
                    3'd2:    colour = 16'h07FF;
                    3'd3:    colour = 16'h07E0;
                    3'd4:    colour = 16'hF81F;
                    3'd5:    colour = 16'hF800;
                    3'd6:    colour = 16'h001F;
                    default: colour = 16'h0000;
                endcase
            end
            4'd6:    colour = {px[6:2], py[7:2], 5'b0};
            4'd7:    colour = (px[CHECK_SHIFT] ^ py[CHECK_SHIFT]) ? 16'hFFFF : 16'h0000;
            4'd8:    colour = {xy[4:0], px[5:0], py[4:0]};
            4'd9:    colour = (px == 16'd0 || px == 16'(H_PIXELS - 1) ||
                               py == 16'd0 || py == 16'(V_PIXELS - 1)) ? 16'hFFFF : 16'h0000;
            default: colour = 16'h0000;
        endcase
        return colour;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: IDLE exists only to hold off the first pixel for
    // one cycle after reset.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = STREAM;
            STREAM:  state_nxt = STREAM;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: works out the coordinate, pattern and frame count the
    // registers will hold next cycle and derives the pixel from those, so
    // the registered data always matches the registered flags.
    always_comb begin
        x_nxt         = x;
        y_nxt         = y;
        pat_nxt       = pat;
        frame_cnt_nxt = frame_cnt;
        valid_nxt     = 1'b1;

        case (state)
            IDLE: begin
                x_nxt   = '0;
                y_nxt   = '0;
                pat_nxt = pattern;
            end
            default: begin
                if (restart) begin
                    x_nxt   = '0;
                    y_nxt   = '0;
                    pat_nxt = pattern;
                end else if (pix_valid && pix_ready) begin
                    if (x == X_LAST) begin
                        x_nxt = '0;
                        if (y == Y_LAST) begin
                            y_nxt         = '0;
                            frame_cnt_nxt = frame_cnt + 8'd1;
                            pat_nxt       = pattern;
                        end else begin
                            y_nxt = y + YW'(1);
                        end
                    end else begin
                        x_nxt = x + XW'(1);
                    end
                end
            end
        endcase

        xe = 16'(x_nxt);
        ye = 16'(y_nxt);
`ifdef PATTERN_ANIMATE_EN
        // Solid fills ignore x, so the scrolled coordinate can feed every pattern.
        xs = (xe + {8'd0, frame_cnt_nxt}) & 16'(H_PIXELS - 1);
`else
        xs = xe;
`endif
        data_nxt = pixel_colour(pat_nxt, xs, ye);
        sof_nxt  = (x_nxt == '0) && (y_nxt == '0);
        eol_nxt  = (x_nxt == X_LAST);
        eof_nxt  = (x_nxt == X_LAST) && (y_nxt == Y_LAST);
    end

    // Registered datapath and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            pat       <= '0;
            frame_cnt <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_eof   <= 1'b0;
        end else begin
            x         <= x_nxt;
            y         <= y_nxt;
            pat       <= pat_nxt;
            frame_cnt <= frame_cnt_nxt;
            pix_valid <= valid_nxt;
            pix_data  <= data_nxt;
            pix_sof   <= sof_nxt;
            pix_eol   <= eol_nxt;
            pix_eof   <= eof_nxt;
        end
    end

endmodule

// File: tb/tb_st7735_pattern_gen.sv
// Testbench for st7735_pattern_gen (default 128x160 geometry).
module tb_st7735_pattern_gen;

`ifdef PATTERN_ANIMATE_EN
    localparam int ANIM = 1;
`else
    localparam int ANIM = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  pattern;
    logic        restart;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    st7735_pattern_gen #(
        .H_PIXELS(128),
        .V_PIXELS(160),
        .BAR_W(16),
        .CHECK_SHIFT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pattern(pattern),
        .restart(restart),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_data(pix_data),
        .pix_sof(pix_sof),
        .pix_eol(pix_eol),
        .pix_eof(pix_eof),
        .frame_cnt(frame_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Colour-bar table, indexed by the (possibly scrolled) x coordinate.
    function automatic logic [15:0] bar_colour(input int xx);
        case ((xx % 128) / 16)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; restart = 1'b0; pix_ready = 1'b1; pattern = 4'd2;
        repeat (5) step();
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pix_valid); end
        checks++; if (pix_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", pix_data); end
        checks++; if ({pix_sof, pix_eol, pix_eof} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {pix_sof, pix_eol, pix_eof}); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        rst = 1'b0;
        // Cycle after release: still not valid.
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL release_valid_low: got %b expected 0", pix_valid); end
        step();
        checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", pix_valid); end
        checks++; if (pix_data !== 16'hF800) begin errors++; $display("FAIL first_data: got %h expected f800", pix_data); end
        checks++; if ({pix_sof, pix_eol, pix_eof} !== 3'b100) begin errors++; $display("FAIL first_flags: got %b expected 100", {pix_sof, pix_eol, pix_eof}); end
    endtask

    task automatic test_full_frame();
        int eof_cnt = 0, eof_idx = -1, eol_cnt = 0, sof_cnt = 0, bad = 0;
        for (int n = 0; n < 20480; n++) begin
            if (pix_eof) begin eof_cnt++; eof_idx = n; end
            if (pix_eol) eol_cnt++;
            if (pix_sof) sof_cnt++;
            if (pix_data !== 16'hF800 || pix_valid !== 1'b1) bad++;
            step();
        end
        checks++; if (eof_cnt !== 1) begin errors++; $display("FAIL frame_eof_count: got %0d expected 1", eof_cnt); end
        checks++; if (eof_idx !== 20479) begin errors++; $display("FAIL frame_eof_index: got %0d expected 20479", eof_idx); end
        checks++; if (eol_cnt !== 160) begin errors++; $display("FAIL frame_eol_count: got %0d expected 160", eol_cnt); end
        checks++; if (sof_cnt !== 1) begin errors++; $display("FAIL frame_sof_count: got %0d expected 1", sof_cnt); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL frame_red_data: got %0d bad pixels expected 0", bad); end
        checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL frame_cnt_after_frame: got %0d expected 1", frame_cnt); end
        checks++; if (pix_sof !== 1'b1) begin errors++; $display("FAIL second_frame_sof: got %b expected 1", pix_sof); end
    endtask

    task automatic test_colour_bars();
        logic [15:0] line_data [128];
        logic        line_eol  [128];
        int off = ANIM * 1;
        int bad = 0;
        pattern = 4'd5; pix_ready = 1'b1; restart = 1'b1;
        step();
        restart = 1'b0;
        checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL bars_restart_frame_cnt: got %0d expected 1", frame_cnt); end
        checks++; if (pix_sof !== 1'b1) begin errors++; $display("FAIL bars_restart_sof: got %b expected 1", pix_sof); end
        for (int x = 0; x < 128; x++) begin
            line_data[x] = pix_data;
            line_eol[x]  = pix_eol;
            if (pix_data !== bar_colour(x + off)) bad++;
            step();
        end
        checks++; if (line_data[0] !== bar_colour(0 + off)) begin errors++; $display("FAIL bars_px0: got %h expected %h", line_data[0], bar_colour(0 + off)); end
        checks++; if (line_data[15] !== bar_colour(15 + off)) begin errors++; $display("FAIL bars_px15: got %h expected %h", line_data[15], bar_colour(15 + off)); end
        checks++; if (line_data[16] !== bar_colour(16 + off)) begin errors++; $display("FAIL bars_px16: got %h expected %h", line_data[16], bar_colour(16 + off)); end
        checks++; if (line_data[31] !== bar_colour(31 + off)) begin errors++; $display("FAIL bars_px31: got %h expected %h", line_data[31], bar_colour(31 + off)); end
        checks++; if (line_data[127] !== bar_colour(127 + off)) begin errors++; $display("FAIL bars_px127: got %h expected %h", line_data[127], bar_colour(127 + off)); end
        checks++; if (line_eol[127] !== 1'b1 || line_eol[126] !== 1'b0) begin errors++; $display("FAIL bars_eol: got %b%b expected 01", line_eol[126], line_eol[127]); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bars_line: got %0d bad pixels expected 0", bad); end
    endtask

    task automatic test_checker_stall();
        int off = ANIM * 1;
        int n = 0, bad = 0, hold_err = 0, cyc = 0, xx, yy;
        logic        r;
        logic        held = 1'b0;
        logic [18:0] cur, prev;
        logic [15:0] exp_d, d8, d88;
        d8 = 16'hxxxx; d88 = 16'hxxxx; prev = '0;
        pattern = 4'd7; pix_ready = 1'b1; restart = 1'b1;
        step();
        restart = 1'b0;
        while (n <= 1032 && cyc < 6000) begin
            cur = {pix_data, pix_sof, pix_eol, pix_eof};
            if (held && cur !== prev) hold_err++;
            r = 1'($urandom_range(0, 1));
            pix_ready = r;
            if (r) begin
                xx = n % 128; yy = n / 128;
                exp_d = (((((xx + off) % 128) >> 3) ^ (yy >> 3)) & 1) != 0 ? 16'hFFFF : 16'h0000;
                if (pix_data !== exp_d || pix_sof !== (n == 0) || pix_eol !== (xx == 127)) bad++;
                if (n == 8) d8 = pix_data;
                if (n == 1032) d88 = pix_data;
                n++;
            end
            prev = cur;
            held = !r;
            cyc++;
            step();
        end
        pix_ready = 1'b1;
        checks++; if (n !== 1033) begin errors++; $display("FAIL checker_progress: got %0d accepts expected 1033", n); end
        checks++; if (hold_err !== 0) begin errors++; $display("FAIL checker_hold: got %0d changes under stall expected 0", hold_err); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL checker_sequence: got %0d bad pixels expected 0", bad); end
        checks++; if (d8 !== 16'hFFFF) begin errors++; $display("FAIL checker_8_0: got %h expected ffff", d8); end
        checks++; if (d88 !== 16'h0000) begin errors++; $display("FAIL checker_8_8: got %h expected 0000", d88); end
    endtask

    task automatic test_pattern_switch();
        int bad = 0;
        pattern = 4'd1; pix_ready = 1'b1; restart = 1'b1;
        step();
        restart = 1'b0;
        for (int n = 0; n < 20480; n++) begin
            if (n == 5000) pattern = 4'd3;
            if (pix_data !== 16'hFFFF) bad++;
            step();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL switch_frame_white: got %0d bad pixels expected 0", bad); end
        checks++; if (pix_sof !== 1'b1) begin errors++; $display("FAIL switch_next_sof: got %b expected 1", pix_sof); end
        checks++; if (pix_data !== 16'h07E0) begin errors++; $display("FAIL switch_next_green: got %h expected 07e0", pix_data); end
        checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL switch_frame_cnt: got %0d expected 2", frame_cnt); end
    endtask

    task automatic test_restart_and_reset();
        pix_ready = 1'b1;
        repeat (300) step();
        checks++; if (pix_sof !== 1'b0 || pix_data !== 16'h07E0) begin errors++; $display("FAIL pre_restart_px300: got sof %b data %h expected sof 0 data 07e0", pix_sof, pix_data); end
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++; if (pix_sof !== 1'b1 || pix_eol !== 1'b0) begin errors++; $display("FAIL restart_sof: got sof %b eol %b expected 1 0", pix_sof, pix_eol); end
        checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL restart_frame_cnt: got %0d expected 2", frame_cnt); end
        checks++; if (pix_data !== 16'h07E0) begin errors++; $display("FAIL restart_data: got %h expected 07e0", pix_data); end
        repeat (900) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", pix_valid); end
        checks++; if (frame_cnt !== 8'd0 || pix_data !== 16'h0000 || pix_sof !== 1'b0) begin errors++; $display("FAIL midreset_state: got cnt %0d data %h sof %b expected 0 0000 0", frame_cnt, pix_data, pix_sof); end
        step();
        checks++; if (pix_valid !== 1'b1 || pix_sof !== 1'b1) begin errors++; $display("FAIL midreset_resume: got valid %b sof %b expected 1 1", pix_valid, pix_sof); end
        checks++; if (pix_data !== 16'h07E0) begin errors++; $display("FAIL midreset_data: got %h expected 07e0", pix_data); end
    endtask

    // Runs with frame_cnt = 0, so scrolling (if built in) has no offset.
    task automatic test_misc_patterns();
        pix_ready = 1'b1;
        pattern = 4'd9; restart = 1'b1; step(); restart = 1'b0;
        checks++; if (pix_data !== 16'hFFFF) begin errors++; $display("FAIL border_0_0: got %h expected ffff", pix_data); end
        step();
        checks++; if (pix_data !== 16'hFFFF) begin errors++; $display("FAIL border_1_0: got %h expected ffff", pix_data); end
        repeat (127) step();
        checks++; if (pix_data !== 16'hFFFF) begin errors++; $display("FAIL border_0_1: got %h expected ffff", pix_data); end
        step();
        checks++; if (pix_data !== 16'h0000) begin errors++; $display("FAIL border_1_1: got %h expected 0000", pix_data); end
        repeat (126) step();
        checks++; if (pix_data !== 16'hFFFF || pix_eol !== 1'b1) begin errors++; $display("FAIL border_127_1: got %h eol %b expected ffff 1", pix_data, pix_eol); end

        pattern = 4'd6; restart = 1'b1; step(); restart = 1'b0;
        repeat (4) step();
        checks++; if (pix_data !== 16'h0800) begin errors++; $display("FAIL gradient_4_0: got %h expected 0800", pix_data); end
        repeat (508) step();
        checks++; if (pix_data !== 16'h0020) begin errors++; $display("FAIL gradient_0_4: got %h expected 0020", pix_data); end

        pattern = 4'd8; restart = 1'b1; step(); restart = 1'b0;
        repeat (389) step();
        checks++; if (pix_data !== 16'h30A3) begin errors++; $display("FAIL xor_5_3: got %h expected 30a3", pix_data); end

        pattern = 4'd4; restart = 1'b1; step(); restart = 1'b0;
        checks++; if (pix_data !== 16'h001F) begin errors++; $display("FAIL blue_0_0: got %h expected 001f", pix_data); end
        pattern = 4'd12; restart = 1'b1; step(); restart = 1'b0;
        checks++; if (pix_data !== 16'h0000) begin errors++; $display("FAIL pattern12_0_0: got %h expected 0000", pix_data); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL misc_frame_cnt: got %0d expected 0", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_colour_bars();
        test_checker_stall();
        test_pattern_switch();
        test_restart_and_reset();
        test_misc_patterns();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
